// File: rtl/control_cmd_dispatch.sv
// Command-stream front end: decodes the opcode byte, forwards the payload bytes to
// the granted sub-command handler, and owns the shared framebuffer write port.
module control_cmd_dispatch #(
  parameter int unsigned           NUM_CMDS        = 2,
  parameter logic [NUM_CMDS*8-1:0] OPCODE_LIST     = 16'h504C,
  parameter int unsigned           BYTES_PER_PIXEL = 2,
  parameter int unsigned           PIXEL_HEIGHT    = 64,
  parameter int unsigned           PIXEL_WIDTH     = 64,
  parameter int unsigned           TIMEOUT_CYCLES  = 4096,
  localparam int unsigned RB = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1,
  localparam int unsigned CB = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int unsigned PB = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  localparam int unsigned SW = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_in,
  output logic [NUM_CMDS-1:0]    sub_enable,
  output logic [7:0]             sub_data,
  input  logic [NUM_CMDS-1:0]    sub_done,
  input  logic [NUM_CMDS*RB-1:0] sub_row,
  input  logic [NUM_CMDS*CB-1:0] sub_col,
  input  logic [NUM_CMDS*PB-1:0] sub_pixel,
  input  logic [NUM_CMDS*8-1:0]  sub_do,
  input  logic [NUM_CMDS-1:0]    sub_we,
  input  logic [NUM_CMDS-1:0]    sub_as,
  output logic [RB-1:0]          ram_row,
  output logic [CB-1:0]          ram_col,
  output logic [PB-1:0]          ram_pixel,
  output logic [7:0]             ram_do,
  output logic                   ram_we,
  output logic                   ram_as,
  output logic                   busy,
  output logic [SW-1:0]          active_sel,
  output logic                   cmd_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_CMDS-1:0] sub_enable_q, sub_enable_d;
  logic [7:0]          sub_data_q, sub_data_d;
  logic                cmd_error_q, cmd_error_d;
  logic                ram_as_q, ram_as_d;
  logic [NUM_CMDS-1:0] prev_as_q, prev_as_d;

  logic                match_hit;
  logic [SW-1:0]       match_idx;

  // Opcode lookup; scanning downward leaves the lowest matching index on duplicates
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = int'(NUM_CMDS) - 1; i >= 0; i--) begin
      if (byte_in == OPCODE_LIST[8*i +: 8]) begin
        match_hit = 1'b1;
        match_idx = SW'(i);
      end
    end
  end

  // Next-state, byte forwarding, timeout and access-start regeneration
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    timer_d      = timer_q;
    sub_enable_d = '0;
    sub_data_d   = sub_data_q;
    cmd_error_d  = 1'b0;
    ram_as_d     = ram_as_q;
    prev_as_d    = sub_as;

    unique case (state_q)
      ST_IDLE: begin
        if (byte_valid) begin
          if (match_hit) begin
            state_d = ST_DISPATCH;
            sel_d   = match_idx;
            timer_d = '0;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      ST_DISPATCH: begin
        // Only the granted handler's toggles are reflected, including in its done cycle
        if (sub_as[sel_q] != prev_as_q[sel_q]) begin
          ram_as_d = ~ram_as_q;
        end
        if (sub_done[sel_q]) begin
          // A byte arriving with done belongs to the next command, not this handler
          state_d = ST_IDLE;
          timer_d = '0;
          if (byte_valid) begin
            if (match_hit) begin
              state_d = ST_DISPATCH;
              sel_d   = match_idx;
            end else begin
              cmd_error_d = 1'b1;
            end
          end
        end else if (byte_valid) begin
          sub_enable_d[sel_q] = 1'b1;
          sub_data_d          = byte_in;
          timer_d             = '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          cmd_error_d = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      timer_q      <= '0;
      sub_enable_q <= '0;
      sub_data_q   <= '0;
      cmd_error_q  <= 1'b0;
      ram_as_q     <= 1'b0;
      prev_as_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      timer_q      <= timer_d;
      sub_enable_q <= sub_enable_d;
      sub_data_q   <= sub_data_d;
      cmd_error_q  <= cmd_error_d;
      ram_as_q     <= ram_as_d;
      prev_as_q    <= prev_as_d;
    end
  end

  // RAM port mux: granted handler's fields while dispatching, quiet otherwise
  always_comb begin
    ram_row   = '0;
    ram_col   = '0;
    ram_pixel = '0;
    ram_do    = '0;
    ram_we    = 1'b0;
    if (state_q == ST_DISPATCH) begin
      ram_row   = sub_row[sel_q*RB +: RB];
      ram_col   = sub_col[sel_q*CB +: CB];
      ram_pixel = sub_pixel[sel_q*PB +: PB];
      ram_do    = sub_do[sel_q*8 +: 8];
      ram_we    = sub_we[sel_q];
    end
  end

  assign sub_enable = sub_enable_q;
  assign sub_data   = sub_data_q;
  assign cmd_error  = cmd_error_q;
  assign ram_as     = ram_as_q;
  assign busy       = (state_q == ST_DISPATCH);
  assign active_sel = sel_q;

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Bench for control_cmd_dispatch: scripted vectors, timeout and reset sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_control_cmd_dispatch;

  localparam int NUM = 2;
  localparam int RB  = 6;
  localparam int CB  = 6;
  localparam int PB  = 1;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic bv;
  logic [7:0] bin;
  logic [1:0] done;
  logic [1:0] h_we;
  logic [1:0] h_as;
  logic [RB-1:0] h_row [NUM];
  logic [CB-1:0] h_col [NUM];
  logic [PB-1:0] h_pix [NUM];
  logic [7:0]    h_do  [NUM];

  logic [NUM-1:0]    sub_enable;
  logic [7:0]        sub_data;
  logic [NUM*RB-1:0] sub_row;
  logic [NUM*CB-1:0] sub_col;
  logic [NUM*PB-1:0] sub_pixel;
  logic [NUM*8-1:0]  sub_do;
  logic [RB-1:0]     ram_row;
  logic [CB-1:0]     ram_col;
  logic [PB-1:0]     ram_pixel;
  logic [7:0]        ram_do;
  logic              ram_we, ram_as, busy, cmd_error;
  logic [0:0]        active_sel;

  assign sub_row   = {h_row[1], h_row[0]};
  assign sub_col   = {h_col[1], h_col[0]};
  assign sub_pixel = {h_pix[1], h_pix[0]};
  assign sub_do    = {h_do[1], h_do[0]};

  control_cmd_dispatch dut (
    .clk(clk), .reset(rst_n), .byte_valid(bv), .byte_in(bin),
    .sub_enable(sub_enable), .sub_data(sub_data), .sub_done(done),
    .sub_row(sub_row), .sub_col(sub_col), .sub_pixel(sub_pixel), .sub_do(sub_do),
    .sub_we(h_we), .sub_as(h_as),
    .ram_row(ram_row), .ram_col(ram_col), .ram_pixel(ram_pixel), .ram_do(ram_do),
    .ram_we(ram_we), .ram_as(ram_as), .busy(busy), .active_sel(active_sel),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a command session is either open (owned by one handler) or not
  logic [7:0] ops [NUM] = '{8'h4C, 8'h50};
  bit       m_busy;
  int       m_sel;
  int       m_quiet;
  bit [1:0] m_prev_as;
  bit       m_ras;
  bit [7:0] m_data;
  bit [1:0] m_en;
  bit       m_err;

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_quiet = 0; m_prev_as = 2'b00;
    m_ras = 0; m_data = 8'h00; m_en = 2'b00; m_err = 0;
  endtask

  task automatic model_decode(input logic [7:0] b);
    int hit = -1;
    for (int i = NUM - 1; i >= 0; i--) if (b == ops[i]) hit = i;
    if (hit >= 0) begin
      m_busy = 1; m_sel = hit; m_quiet = 0;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic model_update();
    m_en  = 2'b00;
    m_err = 0;
    if (m_busy && (h_as[m_sel] != m_prev_as[m_sel])) m_ras = !m_ras;
    if (!m_busy) begin
      if (bv) model_decode(bin);
    end else if (done[m_sel]) begin
      m_busy = 0;
      if (bv) model_decode(bin);
    end else if (bv) begin
      m_en[m_sel] = 1'b1;
      m_data = bin;
      m_quiet = 0;
    end else begin
      m_quiet++;
      if (m_quiet == TIMEOUT) begin
        m_busy = 0;
        m_err = 1;
      end
    end
    m_prev_as = h_as;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic chk_all(input int idx);
    chk("m_en", idx, sub_enable, m_en);
    chk("m_data", idx, sub_data, m_data);
    chk("m_err", idx, cmd_error, m_err);
    chk("m_busy", idx, busy, m_busy);
    chk("m_sel", idx, active_sel, m_sel);
    chk("m_ras", idx, ram_as, m_ras);
    chk("m_rwe", idx, ram_we, m_busy ? h_we[m_sel] : 1'b0);
    chk("m_row", idx, ram_row, m_busy ? h_row[m_sel] : '0);
    chk("m_col", idx, ram_col, m_busy ? h_col[m_sel] : '0);
    chk("m_pix", idx, ram_pixel, m_busy ? h_pix[m_sel] : '0);
    chk("m_do", idx, ram_do, m_busy ? h_do[m_sel] : '0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    model_update();
  endtask

  task automatic send(input logic [7:0] b);
    bv = 1'b1; bin = b;
    tick();
    bv = 1'b0; bin = 8'h00;
  endtask

  typedef struct packed {
    logic       bv;
    logic [7:0] byt;
    logic [1:0] done;
    logic [1:0] as;
    logic [1:0] we;
    logic       e_busy;
    logic       e_sel;
    logic [1:0] e_en;
    logic [7:0] e_data;
    logic       e_err;
    logic       e_ras;
    logic       e_rwe;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] b, logic [1:0] d, logic [1:0] a, logic [1:0] w,
                              logic eb, logic es, logic [1:0] ee, logic [7:0] ed,
                              logic er, logic ea, logic ew);
    vec_t r;
    r.bv = v; r.byt = b; r.done = d; r.as = a; r.we = w;
    r.e_busy = eb; r.e_sel = es; r.e_en = ee; r.e_data = ed;
    r.e_err = er; r.e_ras = ea; r.e_rwe = ew;
    return r;
  endfunction

  vec_t tbl [27];

  initial begin
    int k;
    int n_en;
    // readpixel-style stream, handler 0 writes after AA and after BB (done cycle)
    tbl[0]  = mk(1, 8'h4C, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 8'h03, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 8'h03, 0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 8'h03, 0, 0, 0);
    tbl[3]  = mk(1, 8'h05, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 8'h05, 0, 0, 0);
    tbl[4]  = mk(1, 8'h00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 8'h00, 0, 0, 0);
    tbl[5]  = mk(1, 8'hAA, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 8'hAA, 0, 0, 0);
    tbl[6]  = mk(0, 8'h00, 2'b00, 2'b01, 2'b01, 1, 0, 2'b00, 8'hAA, 0, 1, 1);
    tbl[7]  = mk(0, 8'h00, 2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 8'hAA, 0, 1, 0);
    tbl[8]  = mk(1, 8'hBB, 2'b00, 2'b01, 2'b00, 1, 0, 2'b01, 8'hBB, 0, 1, 0);
    tbl[9]  = mk(0, 8'h00, 2'b01, 2'b00, 2'b01, 0, 0, 2'b00, 8'hBB, 0, 0, 0);
    tbl[10] = mk(0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 8'hBB, 0, 0, 0);
    // toggles from the non-granted handler must not reach ram_as
    tbl[11] = mk(1, 8'h4C, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 8'hBB, 0, 0, 0);
    tbl[12] = mk(0, 8'h00, 2'b00, 2'b10, 2'b00, 1, 0, 2'b00, 8'hBB, 0, 0, 0);
    tbl[13] = mk(0, 8'h00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 8'hBB, 0, 0, 0);
    tbl[14] = mk(0, 8'h00, 2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 8'hBB, 0, 1, 0);
    tbl[15] = mk(0, 8'h00, 2'b00, 2'b11, 2'b00, 1, 0, 2'b00, 8'hBB, 0, 1, 0);
    tbl[16] = mk(0, 8'h00, 2'b01, 2'b11, 2'b00, 0, 0, 2'b00, 8'hBB, 0, 1, 0);
    // done coincident with the next opcode
    tbl[17] = mk(1, 8'h4C, 2'b00, 2'b11, 2'b00, 1, 0, 2'b00, 8'hBB, 0, 1, 0);
    tbl[18] = mk(1, 8'h11, 2'b00, 2'b11, 2'b00, 1, 0, 2'b01, 8'h11, 0, 1, 0);
    tbl[19] = mk(1, 8'h50, 2'b01, 2'b11, 2'b00, 1, 1, 2'b00, 8'h11, 0, 1, 0);
    tbl[20] = mk(1, 8'h22, 2'b00, 2'b11, 2'b10, 1, 1, 2'b10, 8'h22, 0, 1, 1);
    tbl[21] = mk(0, 8'h00, 2'b10, 2'b11, 2'b00, 0, 1, 2'b00, 8'h22, 0, 1, 0);
    // unknown opcode, then done from the wrong handler
    tbl[22] = mk(1, 8'h7E, 2'b00, 2'b11, 2'b00, 0, 1, 2'b00, 8'h22, 1, 1, 0);
    tbl[23] = mk(0, 8'h00, 2'b00, 2'b11, 2'b00, 0, 1, 2'b00, 8'h22, 0, 1, 0);
    tbl[24] = mk(1, 8'h4C, 2'b00, 2'b11, 2'b00, 1, 0, 2'b00, 8'h22, 0, 1, 0);
    tbl[25] = mk(0, 8'h00, 2'b10, 2'b11, 2'b00, 1, 0, 2'b00, 8'h22, 0, 1, 0);
    tbl[26] = mk(0, 8'h00, 2'b01, 2'b11, 2'b00, 0, 0, 2'b00, 8'h22, 0, 1, 0);

    rst_n = 1'b0; bv = 1'b0; bin = 8'h00; done = 2'b00; h_we = 2'b00; h_as = 2'b00;
    for (int i = 0; i < NUM; i++) begin
      h_row[i] = '0; h_col[i] = '0; h_pix[i] = '0; h_do[i] = '0;
    end
    model_reset();
    #12;
    chk("rst_busy", 0, busy, 0);
    chk("rst_en", 0, sub_enable, 0);
    chk("rst_err", 0, cmd_error, 0);
    chk("rst_ras", 0, ram_as, 0);
    chk("rst_rwe", 0, ram_we, 0);
    chk("rst_data", 0, sub_data, 0);
    chk("rst_sel", 0, active_sel, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      bv = tbl[i].bv; bin = tbl[i].byt; done = tbl[i].done; h_as = tbl[i].as; h_we = tbl[i].we;
      tick();
      chk("tbl_busy", i, busy, tbl[i].e_busy);
      chk("tbl_sel", i, active_sel, tbl[i].e_sel);
      chk("tbl_en", i, sub_enable, tbl[i].e_en);
      chk("tbl_data", i, sub_data, tbl[i].e_data);
      chk("tbl_err", i, cmd_error, tbl[i].e_err);
      chk("tbl_ras", i, ram_as, tbl[i].e_ras);
      chk("tbl_rwe", i, ram_we, tbl[i].e_rwe);
    end
    bv = 1'b0; done = 2'b00; h_we = 2'b00;

    // Timeout: opcode then silence
    send(8'h4C);
    k = 0;
    for (int c = 1; c <= 5000; c++) begin
      tick();
      if (c == 4095) chk("pre_to_busy", c, busy, 1);
      if (cmd_error) begin
        k = c;
        break;
      end
    end
    chk("to_cycle", 0, k, TIMEOUT);
    chk("to_busy", 0, busy, 0);
    chk("to_en", 0, sub_enable, 0);
    send(8'h50);
    chk("post_to_busy", 0, busy, 1);
    chk("post_to_sel", 0, active_sel, 1);
    chk("post_to_err", 0, cmd_error, 0);
    done = 2'b10; tick(); done = 2'b00;
    chk("post_to_idle", 0, busy, 0);

    // Reset in the middle of a command
    send(8'h4C); send(8'h03); send(8'h05); send(8'h00); send(8'hAA);
    h_as = ~h_as; h_we = 2'b01; tick();
    chk("pre_rst_rwe", 0, ram_we, 1);
    chk("pre_rst_ras", 0, ram_as, !tbl[26].e_ras);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rwe", 0, ram_we, 0);
    chk("arst_ras", 0, ram_as, 0);
    chk("arst_busy", 0, busy, 0);
    chk("arst_en", 0, sub_enable, 0);
    chk("arst_data", 0, sub_data, 0);
    model_reset();
    h_as = 2'b00; h_we = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    n_en = 0;
    send(8'h4C); chk_all(0); n_en += int'(sub_enable[0]);
    send(8'h03); chk_all(1); n_en += int'(sub_enable[0]);
    send(8'h05); chk_all(2); n_en += int'(sub_enable[0]);
    send(8'h00); chk_all(3); n_en += int'(sub_enable[0]);
    send(8'hAA); chk_all(4); n_en += int'(sub_enable[0]);
    send(8'hBB); chk_all(5); n_en += int'(sub_enable[0]);
    done = 2'b01; tick(); done = 2'b00;
    chk("rel_en_count", 0, n_en, 5);
    chk("rel_idle", 0, busy, 0);
    chk("rel_data", 0, sub_data, 8'hBB);
    chk("rel_ras", 0, ram_as, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      bv = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 7);
      bin = (r < 2) ? 8'h4C : (r == 2) ? 8'h50 : 8'($urandom);
      done[0] = ($urandom_range(0, 11) == 0);
      done[1] = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) h_as[0] = ~h_as[0];
      if ($urandom_range(0, 7) == 0) h_as[1] = ~h_as[1];
      h_we = 2'($urandom);
      for (int i = 0; i < NUM; i++) begin
        h_row[i] = RB'($urandom); h_col[i] = CB'($urandom);
        h_pix[i] = PB'($urandom); h_do[i] = 8'($urandom);
      end
      tick();
      chk_all(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
